// File: rtl/i2c_adc_target.sv
// I2C target exposing a four-register map: conversion result (0, read-only), config (1) and thresholds (2, 3).
// SCL/SDA are oversampled on clk; all protocol actions happen on synchronized bus edges.
module i2c_adc_target #(
    parameter logic [6:0] ADDRESS = 7'b1001001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl,
    input  logic        sdaIn,
    output logic        sdaOut,
    output logic        isSending,
    input  logic [15:0] convData,
    input  logic        convLoad,
    output logic [15:0] configReg,
    output logic [15:0] loThresh,
    output logic [15:0] hiThresh,
    output logic        regWritePulse,
    output logic [1:0]  regWriteAddr,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } stateType;

    stateType    state, stateNext;

    logic [1:0]  sclSync, sdaSync;
    logic        sclLast, sdaLast;
    logic        sdaBit, sclRise, sclFall, startCond, stopCond, rxDone;

    logic [3:0]  bitCnt, bitCntNext;
    logic [7:0]  rxShift, rxShiftNext;
    logic [15:0] txShift, txShiftNext;
    logic [1:0]  pointer, pointerNext;
    logic [7:0]  msbHold, msbHoldNext;
    logic [1:0]  dataCnt, dataCntNext;
    logic        readMode, readModeNext;
    logic        readLsb, readLsbNext;
    logic        ackBit, ackBitNext;
    logic        sdaOutNext, isSendingNext;
    logic        commit;
    logic [15:0] commitData;
    logic [15:0] convReg;
    logic [15:0] readValue;

    // During reset the synchronizers are preloaded with the live pin levels so
    // that leaving reset mid-transfer cannot fabricate a START or STOP edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclSync <= {2{scl}};
            sdaSync <= {2{sdaIn}};
            sclLast <= scl;
            sdaLast <= sdaIn;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, which the synchronizer chain depends on.
            sclSync <= {sclSync[0], scl};
            sdaSync <= {sdaSync[0], sdaIn};
            sclLast <= sclSync[1];
            sdaLast <= sdaSync[1];
        end
    end

    assign sdaBit    = sdaSync[1];
    assign sclRise   = sclSync[1] & ~sclLast;
    assign sclFall   = ~sclSync[1] & sclLast;
    assign startCond = ~sdaSync[1] & sdaLast & sclSync[1] & sclLast;
    assign stopCond  = sdaSync[1] & ~sdaLast & sclSync[1] & sclLast;
    assign rxDone    = sclFall && (bitCnt == 4'd8);
    assign busy      = (state != IDLE);
    assign commitData = {msbHold, rxShift};

    always_comb begin
        case (pointer)
            2'd0:    readValue = convReg;
            2'd1:    readValue = configReg;
            2'd2:    readValue = loThresh;
            default: readValue = hiThresh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bitCnt    <= '0;
            rxShift   <= '0;
            txShift   <= '0;
            pointer   <= '0;
            msbHold   <= '0;
            dataCnt   <= '0;
            readMode  <= 1'b0;
            readLsb   <= 1'b0;
            ackBit    <= 1'b1;
            sdaOut    <= 1'b1;
            isSending <= 1'b0;
        end else begin
            state     <= stateNext;
            bitCnt    <= bitCntNext;
            rxShift   <= rxShiftNext;
            txShift   <= txShiftNext;
            pointer   <= pointerNext;
            msbHold   <= msbHoldNext;
            dataCnt   <= dataCntNext;
            readMode  <= readModeNext;
            readLsb   <= readLsbNext;
            ackBit    <= ackBitNext;
            sdaOut    <= sdaOutNext;
            isSending <= isSendingNext;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a missing branch would otherwise infer a latch.
        stateNext     = state;
        bitCntNext    = bitCnt;
        rxShiftNext   = rxShift;
        txShiftNext   = txShift;
        pointerNext   = pointer;
        msbHoldNext   = msbHold;
        dataCntNext   = dataCnt;
        readModeNext  = readMode;
        readLsbNext   = readLsb;
        ackBitNext    = ackBit;
        sdaOutNext    = sdaOut;
        isSendingNext = isSending;
        commit        = 1'b0;

        if (stopCond) begin
            stateNext     = IDLE;
            sdaOutNext    = 1'b1;
            isSendingNext = 1'b0;
        end else if (startCond) begin
            stateNext     = ADDR;
            bitCntNext    = '0;
            sdaOutNext    = 1'b1;
            isSendingNext = 1'b0;
        end else begin
            if (sclRise && (state == ADDR || state == PTR || state == WDATA)) begin
                rxShiftNext = {rxShift[6:0], sdaBit};
                bitCntNext  = bitCnt + 4'd1;
            end

            case (state)
                ADDR: begin
                    if (rxDone) begin
                        bitCntNext = '0;
                        if (rxShift[7:1] == ADDRESS) begin
                            stateNext     = ADDR_ACK;
                            sdaOutNext    = 1'b0;
                            isSendingNext = 1'b1;
                            readModeNext  = rxShift[0];
                            if (rxShift[0]) begin
                                txShiftNext = readValue;
                                readLsbNext = 1'b0;
                            end
                        end else begin
                            stateNext = WAIT_STOP;
                        end
                    end
                end

                ADDR_ACK: begin
                    if (sclFall) begin
                        bitCntNext = '0;
                        if (readMode) begin
                            // First data bit goes out on the same SCL fall that ends the ACK.
                            stateNext     = RDATA;
                            sdaOutNext    = txShift[15];
                            txShiftNext   = {txShift[14:0], 1'b0};
                            isSendingNext = 1'b1;
                        end else begin
                            stateNext     = PTR;
                            sdaOutNext    = 1'b1;
                            isSendingNext = 1'b0;
                        end
                    end
                end

                PTR: begin
                    if (rxDone) begin
                        stateNext     = PTR_ACK;
                        pointerNext   = rxShift[1:0];
                        dataCntNext   = '0;
                        sdaOutNext    = 1'b0;
                        isSendingNext = 1'b1;
                    end
                end

                PTR_ACK, WDATA_ACK: begin
                    if (sclFall) begin
                        stateNext     = WDATA;
                        bitCntNext    = '0;
                        sdaOutNext    = 1'b1;
                        isSendingNext = 1'b0;
                    end
                end

                WDATA: begin
                    if (rxDone) begin
                        if (dataCnt == 2'd2) begin
                            stateNext = WAIT_STOP;
                        end else begin
                            stateNext     = WDATA_ACK;
                            sdaOutNext    = 1'b0;
                            isSendingNext = 1'b1;
                            dataCntNext   = dataCnt + 2'd1;
                            if (dataCnt == 2'd0) begin
                                msbHoldNext = rxShift;
                            end else begin
                                commit = (pointer != 2'd0);
                            end
                        end
                    end
                end

                RDATA: begin
                    if (sclRise) begin
                        bitCntNext = bitCnt + 4'd1;
                    end else if (sclFall) begin
                        if (bitCnt == 4'd8) begin
                            stateNext     = RDATA_ACK;
                            sdaOutNext    = 1'b1;
                            isSendingNext = 1'b0;
                        end else begin
                            sdaOutNext  = txShift[15];
                            txShiftNext = {txShift[14:0], 1'b0};
                        end
                    end
                end

                RDATA_ACK: begin
                    if (sclRise) begin
                        ackBitNext = sdaBit;
                    end else if (sclFall) begin
                        if (!ackBit) begin
                            stateNext     = RDATA;
                            bitCntNext    = '0;
                            isSendingNext = 1'b1;
                            if (readLsb) begin
                                // Both bytes delivered: take a fresh snapshot and restart at the MSB.
                                sdaOutNext  = readValue[15];
                                txShiftNext = {readValue[14:0], 1'b0};
                                readLsbNext = 1'b0;
                            end else begin
                                sdaOutNext  = txShift[15];
                                txShiftNext = {txShift[14:0], 1'b0};
                                readLsbNext = 1'b1;
                            end
                        end else begin
                            stateNext = WAIT_STOP;
                        end
                    end
                end

                default: ;
            endcase
        end
    end

    // Register 0 is only ever written by convLoad and commits never target it,
    // so the two update paths below can never collide on the same register.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the register file is reset because its power-on contents are architecturally visible over the bus.
            convReg       <= 16'h0000;
            configReg     <= 16'h8583;
            loThresh      <= 16'h8000;
            hiThresh      <= 16'h7FFF;
            regWritePulse <= 1'b0;
            regWriteAddr  <= 2'd0;
        end else begin
            regWritePulse <= commit;
            if (commit) begin
                regWriteAddr <= pointer;
                case (pointer)
                    2'd1:    configReg <= commitData;
                    2'd2:    loThresh  <= commitData;
                    2'd3:    hiThresh  <= commitData;
                    default: ;
                endcase
            end
            if (convLoad) begin
                convReg <= convData;
            end
        end
    end

endmodule

// File: tb/tb_i2c_adc_target.sv
// Self-checking bench for i2c_adc_target: bit-banged initiator, directed sequences,
// a table of write/readback vectors and randomized transactions against a register-map model.
module tb_i2c_adc_target;

    localparam logic [6:0] ADDR7 = 7'b1001001;
    localparam int Q = 4;

    logic        clk = 1'b0;
    logic        reset, scl, sdaM, sdaLine, sdaOut, isSending, convLoad, regWritePulse, busy;
    logic [15:0] convData, configReg, loThresh, hiThresh;
    logic [1:0]  regWriteAddr;

    always #5 clk = ~clk;

    // Open-drain bus: the target can only pull the line low.
    assign sdaLine = sdaM & ~(isSending & ~sdaOut);

    i2c_adc_target #(.ADDRESS(ADDR7)) dut (
        .clk(clk), .reset(reset), .scl(scl), .sdaIn(sdaLine), .sdaOut(sdaOut),
        .isSending(isSending), .convData(convData), .convLoad(convLoad),
        .configReg(configReg), .loThresh(loThresh), .hiThresh(hiThresh),
        .regWritePulse(regWritePulse), .regWriteAddr(regWriteAddr), .busy(busy)
    );

    int checks = 0;
    int failures = 0;
    int sendCycles = 0;
    int strobeCount = 0;

    always @(negedge clk) begin
        if (isSending) sendCycles++;
        if (regWritePulse) strobeCount++;
    end

    // Register-map model
    logic [15:0] mregs [4];
    logic [1:0]  mptr;

    typedef struct {
        logic [7:0]  ptrByte;
        logic [15:0] data;
        int          expStrobe;
        logic [15:0] expRead;
        logic [1:0]  expAddr;
    } vecT;

    vecT vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic busStart();
        sdaM = 1'b1; tick(Q);
        scl  = 1'b1; tick(Q);
        sdaM = 1'b0; tick(Q);
        scl  = 1'b0; tick(Q);
    endtask

    task automatic busStop();
        sdaM = 1'b0; tick(Q);
        scl  = 1'b1; tick(Q);
        sdaM = 1'b1; tick(Q);
    endtask

    task automatic xferBit(input logic b, output logic s);
        sdaM = b;    tick(Q);
        scl  = 1'b1; tick(Q);
        s    = sdaLine;
        tick(Q);
        scl  = 1'b0; tick(Q);
    endtask

    task automatic writeByte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) xferBit(d[i], s);
        xferBit(1'b1, s);
        ack = ~s;
    endtask

    task automatic readByte(input logic ackIt, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            xferBit(1'b1, s);
            d[i] = s;
        end
        xferBit(~ackIt, s);
    endtask

    task automatic loadConv(input logic [15:0] v);
        convData = v;
        convLoad = 1'b1;
        tick(1);
        convLoad = 1'b0;
    endtask

    task automatic writeTxn(input logic [7:0] ptrByte, input int nData, input logic [23:0] data,
                            output logic [4:0] acks);
        logic a;
        acks = '0;
        busStart();
        writeByte({ADDR7, 1'b0}, a); acks[4] = a;
        writeByte(ptrByte, a);       acks[3] = a;
        for (int i = 0; i < nData; i++) begin
            writeByte(data[23-8*i -: 8], a);
            acks[2-i] = a;
        end
        busStop();
    endtask

    task automatic readTxn(input int n, output logic addrAck, output logic [39:0] bytes);
        logic [7:0] b;
        bytes = '0;
        busStart();
        writeByte({ADDR7, 1'b1}, addrAck);
        for (int i = 0; i < n; i++) begin
            readByte(i != n - 1, b);
            bytes = {bytes[31:0], b};
        end
        busStop();
    endtask

    task automatic modelWrite(input logic [7:0] ptrByte, input int nData, input logic [23:0] data,
                              output int expStrobe, output logic [4:0] expAcks);
        mptr = ptrByte[1:0];
        expStrobe = 0;
        expAcks = 5'b11000 | ((nData >= 1) ? 5'b00100 : 5'b0) | ((nData >= 2) ? 5'b00010 : 5'b0);
        if (nData >= 2 && mptr != 2'd0) begin
            mregs[mptr] = data[23:8];
            expStrobe = 1;
        end
    endtask

    function automatic logic [39:0] expRead(input int n);
        logic [39:0] r;
        logic [15:0] snap;
        r = '0;
        snap = '0;
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) snap = mregs[mptr];
            r = {r[31:0], (i % 2 == 0) ? snap[15:8] : snap[7:0]};
        end
        return r;
    endfunction

    task automatic checkRegs(input string tag);
        check({tag, "_config"}, configReg, mregs[1]);
        check({tag, "_lo"},     loThresh,  mregs[2]);
        check({tag, "_hi"},     hiThresh,  mregs[3]);
        check({tag, "_busy"},   busy,      1'b0);
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_config"}, configReg,     16'h8583);
        check({tag, "_lo"},     loThresh,      16'h8000);
        check({tag, "_hi"},     hiThresh,      16'h7FFF);
        check({tag, "_sdaOut"}, sdaOut,        1'b1);
        check({tag, "_isSend"}, isSending,     1'b0);
        check({tag, "_strobe"}, regWritePulse, 1'b0);
        check({tag, "_waddr"},  regWriteAddr,  2'd0);
        check({tag, "_busy"},   busy,          1'b0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        a0, a1, a2, a3;
        logic [4:0]  acks, expAcks;
        logic [39:0] rd;
        logic [7:0]  b0, b1, b2;
        int          s0, expStrobe;

        vecs[0] = '{8'h02, 16'h0F0F, 1, 16'h0F0F, 2'd2};
        vecs[1] = '{8'h03, 16'hA55A, 1, 16'hA55A, 2'd3};
        vecs[2] = '{8'hFD, 16'h0001, 1, 16'h0001, 2'd1};
        vecs[3] = '{8'h00, 16'hFFFF, 0, 16'h1234, 2'd1};
        vecs[4] = '{8'h7E, 16'h3C3C, 1, 16'h3C3C, 2'd2};

        reset = 1'b1; scl = 1'b1; sdaM = 1'b1; convLoad = 1'b0; convData = '0;
        tick(4);
        reset = 1'b0;
        tick(2);
        checkResetOutputs("reset");
        mregs = '{16'h0000, 16'h8583, 16'h8000, 16'h7FFF};
        mptr = 2'd0;

        readTxn(2, a0, rd);
        check("reset_reg0_ack", a0, 1'b1);
        check("reset_reg0", rd, 40'h0000);

        // convLoad, pointer 0 via write, repeated START, two-byte read
        loadConv(16'h1234); mregs[0] = 16'h1234;
        busStart();
        writeByte(8'h92, a0);
        writeByte(8'h00, a1);
        busStart();
        writeByte(8'h93, a2);
        readByte(1'b1, b0);
        readByte(1'b0, b1);
        busStop();
        check("rs_acks", {a0, a1, a2}, 3'b111);
        check("rs_msb", b0, 8'h12);
        check("rs_lsb", b1, 8'h34);

        // configuration write
        s0 = strobeCount;
        writeTxn(8'h01, 2, 24'hC38300, acks);
        modelWrite(8'h01, 2, 24'hC38300, expStrobe, expAcks);
        check("cfg_acks", acks, 5'b11110);
        check("cfg_value", configReg, 16'hC383);
        check("cfg_strobe", strobeCount - s0, 1);
        check("cfg_waddr", regWriteAddr, 2'd1);

        // foreign address: no ACK, never drives, busy until STOP
        s0 = sendCycles;
        busStart();
        writeByte(8'h94, a0);
        writeByte(8'h5A, a1);
        check("nomatch_busy", busy, 1'b1);
        busStop();
        check("nomatch_ack", {a0, a1}, 2'b00);
        check("nomatch_send", sendCycles - s0, 0);
        check("nomatch_idle", busy, 1'b0);

        // pointer 3 read, ACK four bytes, NACK the fifth
        writeTxn(8'h03, 0, 24'h0, acks);
        modelWrite(8'h03, 0, 24'h0, expStrobe, expAcks);
        check("p3_acks", acks, 5'b11000);
        readTxn(5, a0, rd);
        check("p3_read", rd, 40'h7FFF7FFF7F);

        // write to register 0 is ACKed but ignored; the byte after LSB is NACKed
        s0 = strobeCount;
        writeTxn(8'h00, 3, 24'hABCD11, acks);
        modelWrite(8'h00, 3, 24'hABCD11, expStrobe, expAcks);
        check("w0_acks", acks, 5'b11110);
        check("w0_strobe", strobeCount - s0, 0);
        readTxn(2, a0, rd);
        check("w0_read", rd, 40'h1234);

        for (int i = 0; i < 5; i++) begin
            s0 = strobeCount;
            writeTxn(vecs[i].ptrByte, 2, {vecs[i].data, 8'h00}, acks);
            modelWrite(vecs[i].ptrByte, 2, {vecs[i].data, 8'h00}, expStrobe, expAcks);
            check($sformatf("tbl%0d_acks", i), acks, 5'b11110);
            check($sformatf("tbl%0d_strobe", i), strobeCount - s0, vecs[i].expStrobe);
            check($sformatf("tbl%0d_waddr", i), regWriteAddr, vecs[i].expAddr);
            readTxn(2, a0, rd);
            check($sformatf("tbl%0d_read", i), rd, {24'h0, vecs[i].expRead});
        end

        // convLoad between MSB and LSB leaves the snapshot intact; the wrap re-snapshots
        busStart();
        writeByte(8'h92, a0);
        writeByte(8'h00, a1);
        busStart();
        writeByte(8'h93, a2);
        readByte(1'b1, b0);
        loadConv(16'hBEEF);
        readByte(1'b1, b1);
        readByte(1'b0, b2);
        busStop();
        mptr = 2'd0; mregs[0] = 16'hBEEF;
        check("snap_bytes", {b0, b1, b2}, 24'h1234BE);

        for (int t = 0; t < 25; t++) begin
            int          kind, nData;
            logic [7:0]  ptrByte;
            logic [23:0] data;
            logic [6:0]  badAddr;
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    ptrByte = 8'($urandom);
                    nData   = $urandom_range(0, 3);
                    data    = 24'($urandom);
                    s0 = strobeCount;
                    writeTxn(ptrByte, nData, data, acks);
                    modelWrite(ptrByte, nData, data, expStrobe, expAcks);
                    check("rnd_wr_acks", acks, expAcks);
                    check("rnd_wr_strobe", strobeCount - s0, expStrobe);
                    if (expStrobe == 1) check("rnd_wr_waddr", regWriteAddr, mptr);
                end
                1: begin
                    nData = $urandom_range(1, 4);
                    readTxn(nData, a0, rd);
                    check("rnd_rd_ack", a0, 1'b1);
                    check("rnd_rd_data", rd, expRead(nData));
                end
                2: begin
                    data = 24'($urandom);
                    loadConv(data[15:0]);
                    mregs[0] = data[15:0];
                end
                default: begin
                    badAddr = 7'($urandom);
                    if (badAddr == ADDR7) badAddr = badAddr ^ 7'd1;
                    s0 = sendCycles;
                    busStart();
                    writeByte({badAddr, 1'($urandom)}, a0);
                    writeByte(8'($urandom), a1);
                    busStop();
                    check("rnd_bad_ack", {a0, a1}, 2'b00);
                    check("rnd_bad_send", sendCycles - s0, 0);
                end
            endcase
            checkRegs("rnd");
        end

        // reset in the middle of the MSB byte of a write
        busStart();
        writeByte(8'h92, a0);
        writeByte(8'h01, a1);
        for (int i = 0; i < 4; i++) xferBit(1'b1, a2);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        checkResetOutputs("midrst");
        mregs = '{16'h0000, 16'h8583, 16'h8000, 16'h7FFF};
        mptr = 2'd0;
        sdaM = 1'b1; tick(Q);
        scl  = 1'b1; tick(Q);
        readTxn(2, a3, rd);
        check("midrst_reg0", rd, 40'h0000);
        s0 = strobeCount;
        writeTxn(8'h02, 2, 24'h135700, acks);
        modelWrite(8'h02, 2, 24'h135700, expStrobe, expAcks);
        check("midrst_acks", acks, 5'b11110);
        check("midrst_strobe", strobeCount - s0, 1);
        check("midrst_waddr", regWriteAddr, 2'd2);
        checkRegs("midrst");
        readTxn(2, a0, rd);
        check("midrst_read", rd, 40'h1357);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
